// File: rtl/bbs_stream_generator_pkg.sv
// Shared definitions for the Blum-Blum-Shub stream generator family.
// FSM state encodings are plain constants so older blocks can reuse them unchanged.
package bbs_stream_generator_pkg;

    typedef logic [1:0] bbs_state_t;

    localparam bbs_state_t ST_IDLE   = 2'd0;
    localparam bbs_state_t ST_SQUARE = 2'd1;
    localparam bbs_state_t ST_STALL  = 2'd2;

endpackage

// File: rtl/bbs_serial_squarer.sv
// Bit-serial modular squarer: x^2 mod MOD, one multiplier bit per cycle, MSB first.
// done_o is high in the last step cycle; result_o is valid during that cycle.
module bbs_serial_squarer
    import bbs_stream_generator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned MOD   = 40633
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned    IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   dbl, dbl_red, sum, sum_red, step;

    // Operands always stay below MOD, so a single conditional subtract reduces each sum.
    always_comb begin
        dbl     = acc_q + acc_q;
        dbl_red = (dbl >= MOD_W) ? (dbl - MOD_W) : dbl;
        sum     = dbl_red + {1'b0, x_i};
        sum_red = (sum >= MOD_W) ? (sum - MOD_W) : sum;
        step    = x_i[idx_q] ? sum_red : dbl_red;
    end

    always_comb begin
        acc_d  = acc_q;
        idx_d  = idx_q;
        busy_d = busy_q;
        if (start_i) begin
            acc_d  = '0;
            idx_d  = IDX_W'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = step;
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = busy_q && (idx_q == '0);
    assign result_o = step[WIDTH-1:0];

endmodule

// File: rtl/bbs_stream_generator.sv
// Blum-Blum-Shub random word generator: FSM, seed check, bit packer and output handshake.
// Define BBS_PARITY_EN to extract the XOR of all state bits instead of the state LSB.
module bbs_stream_generator
    import bbs_stream_generator_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MOD      = 40633,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    seed,
    input  logic                seed_valid,
    output logic                seed_ready,
    output logic                seed_err,
    input  logic                stop,
    output logic [WIDTH-1:0]    x_out,
    output logic                x_strobe,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned    CNT_W = $clog2(OUT_BITS) + 1;
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);

    bbs_state_t          state_q, state_d;
    logic [WIDTH-1:0]    x_q, x_d;
    logic                x_strobe_q, x_strobe_d;
    logic                seed_err_q, seed_err_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] part_q, part_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                sq_start;
    logic                sq_busy;
    logic                sq_done;
    logic                sq_finish;
    logic [WIDTH-1:0]    sq_result;
    logic                new_bit;
    logic [OUT_BITS-1:0] next_word;
    logic                word_done;
    logic                transfer;
    logic                seed_ok;

    bbs_serial_squarer #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_squarer (
        .clk      (clk),
        .rst_ni   (reset),
        .start_i  (sq_start),
        .x_i      (x_q),
        .busy_o   (sq_busy),
        .done_o   (sq_done),
        .result_o (sq_result)
    );

`ifdef BBS_PARITY_EN
    assign new_bit = ^sq_result;
`else
    assign new_bit = sq_result[0];
`endif

    assign sq_finish = sq_busy & sq_done;
    assign next_word = OUT_BITS'({part_q, new_bit});
    assign word_done = (cnt_q == CNT_W'(OUT_BITS - 1));
    assign transfer  = out_valid_q & out_ready;
    assign seed_ok   = ({1'b0, seed} > (WIDTH+1)'(1)) && ({1'b0, seed} < MOD_W);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        x_strobe_d  = 1'b0;
        seed_err_d  = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        part_d      = part_q;
        cnt_d       = cnt_q;
        sq_start    = 1'b0;

        if (transfer) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (seed_valid) begin
                    if (seed_ok) begin
                        x_d      = seed;
                        part_d   = '0;
                        cnt_d    = '0;
                        sq_start = 1'b1;
                        state_d  = ST_SQUARE;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end
            end

            ST_SQUARE: begin
                if (sq_finish) begin
                    x_d        = sq_result;
                    x_strobe_d = 1'b1;
                    if (stop) begin
                        part_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (word_done) begin
                        // Output register free (or emptied this cycle): load and keep squaring.
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = next_word;
                            out_valid_d = 1'b1;
                            part_d      = '0;
                            cnt_d       = '0;
                            sq_start    = 1'b1;
                        end else begin
                            part_d  = next_word;
                            state_d = ST_STALL;
                        end
                    end else begin
                        part_d   = next_word;
                        cnt_d    = cnt_q + 1'b1;
                        sq_start = 1'b1;
                    end
                end
            end

            ST_STALL: begin
                if (stop) begin
                    part_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (out_ready) begin
                    out_data_d  = part_q;
                    out_valid_d = 1'b1;
                    part_d      = '0;
                    cnt_d       = '0;
                    sq_start    = 1'b1;
                    state_d     = ST_SQUARE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            x_strobe_q  <= 1'b0;
            seed_err_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            part_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            x_strobe_q  <= x_strobe_d;
            seed_err_q  <= seed_err_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            part_q      <= part_d;
            cnt_q       <= cnt_d;
        end
    end

    assign seed_ready = (state_q == ST_IDLE);
    assign seed_err   = seed_err_q;
    assign x_out      = x_q;
    assign x_strobe   = x_strobe_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_bbs_stream_generator.sv
// Self-checking bench for bbs_stream_generator: directed cases plus randomized seeds
// and consumer back-pressure, checked against an arithmetic model of the BBS stream.
module tb_bbs_stream_generator;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned MOD      = 40633;
    localparam int unsigned OUT_BITS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [WIDTH-1:0]    seed;
    logic                seed_valid;
    logic                seed_ready;
    logic                seed_err;
    logic                stop;
    logic [WIDTH-1:0]    x_out;
    logic                x_strobe;
    logic [OUT_BITS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    always #5 clk = ~clk;

    bbs_stream_generator #(
        .WIDTH    (WIDTH),
        .MOD      (MOD),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seed       (seed),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_err   (seed_err),
        .stop       (stop),
        .x_out      (x_out),
        .x_strobe   (x_strobe),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model of the stream.
    longint unsigned     m_x = 0;
    longint unsigned     m_part = 0;
    int unsigned         m_cnt = 0;
    longint unsigned     m_words[$];
    bit                  model_on = 1'b0;
    bit                  stop_seen = 1'b0;

    int unsigned         cyc = 0;
    int unsigned         n_strobe = 0;
    int unsigned         n_xfer = 0;
    int unsigned         last_strobe_cyc = 0;
    int unsigned         prev_strobe_cyc = 0;
    longint unsigned     last_strobe_x = 0;

    function automatic longint unsigned extract_bit(input longint unsigned v);
`ifdef BBS_PARITY_EN
        return longint'($countones(v) % 2);
`else
        return v % 2;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (model_on) begin
            if (x_strobe === 1'b1) begin
                m_x = (m_x * m_x) % MOD;
                n_strobe++;
                prev_strobe_cyc = last_strobe_cyc;
                last_strobe_cyc = cyc;
                last_strobe_x   = longint'(x_out);
                check_eq("x_out_model", x_out, m_x);
                if (stop_seen) begin
                    m_part = 0;
                    m_cnt  = 0;
                    check_eq("stop_to_idle", seed_ready, 1);
                end else begin
                    m_part = ((m_part * 2) + extract_bit(m_x)) % (64'd1 << OUT_BITS);
                    m_cnt++;
                    if (m_cnt == OUT_BITS) begin
                        m_words.push_back(m_part);
                        m_part = 0;
                        m_cnt  = 0;
                    end
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_xfer++;
                if (m_words.size() == 0) check_eq("unexpected_xfer", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                else check_eq("out_data", out_data, m_words.pop_front());
            end
        end
        stop_seen = stop;
    end

    task automatic offer_seed(input logic [WIDTH-1:0] s, output int unsigned e0);
        seed       = s;
        seed_valid = 1'b1;
        @(posedge clk);
        #1;
        e0         = cyc;
        seed_valid = 1'b0;
        m_x        = longint'(s);
        m_part     = 0;
        m_cnt      = 0;
    endtask

    task automatic offer_bad(input logic [WIDTH-1:0] s);
        seed       = s;
        seed_valid = 1'b1;
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        check_eq("bad_seed_err", seed_err, 1);
        check_eq("bad_seed_ready", seed_ready, 1);
        check_eq("bad_seed_x_hold", x_out, m_x);
        @(posedge clk);
        #1;
        check_eq("bad_seed_err_pulse", seed_err, 0);
    endtask

    task automatic wait_strobes(input int unsigned n);
        int unsigned target;
        int unsigned k;
        target = n_strobe + n;
        k = 0;
        while (n_strobe < target && k < (n + 4) * WIDTH) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (n_strobe < target) check_eq("strobe_timeout", n_strobe, target);
    endtask

    task automatic stop_run();
        int unsigned k;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stop = 1'b1;
        k = 0;
        while (seed_ready !== 1'b1 && k < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            k++;
        end
        stop = 1'b0;
        if (seed_ready !== 1'b1) check_eq("stop_timeout", seed_ready, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int unsigned e0;
        int unsigned s0;
        int unsigned x0;
        int unsigned k;
        int unsigned ncyc;
        logic [WIDTH-1:0] rs;

        reset      = 1'b0;
        seed       = '0;
        seed_valid = 1'b0;
        stop       = 1'b0;
        out_ready  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_x_out", x_out, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_x_strobe", x_strobe, 0);
        check_eq("rst_seed_err", seed_err, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_seed_ready", seed_ready, 1);
        model_on = 1'b1;

        // Known sequence from seed 200, latency and strobe spacing.
        out_ready = 1'b1;
        offer_seed(16'd200, e0);
        wait_strobes(1);
        check_eq("latency", last_strobe_cyc - e0, WIDTH);
        check_eq("x200_1", last_strobe_x, 40000);
        wait_strobes(1);
        check_eq("x200_2", last_strobe_x, 34992);
        check_eq("spacing_2", last_strobe_cyc - prev_strobe_cyc, WIDTH);
        wait_strobes(1);
        check_eq("x200_3", last_strobe_x, 5242);
        check_eq("spacing_3", last_strobe_cyc - prev_strobe_cyc, WIDTH);
        stop_run();

        offer_seed(16'd40600, e0);
        wait_strobes(1);
        check_eq("x40600_1", last_strobe_x, 1089);
        stop_run();
        offer_seed(16'd884, e0);
        wait_strobes(1);
        check_eq("x884_1", last_strobe_x, 9429);
        stop_run();

        offer_bad(16'd40633);
        offer_bad(16'd1);
        offer_bad(16'd0);
        offer_bad(16'hFFFF);

        // Back-pressure: second word completes with the first unconsumed -> stall.
        out_ready = 1'b0;
        offer_seed(16'd200, e0);
        wait_strobes(2 * OUT_BITS);
        check_eq("stall_valid", out_valid, 1);
        check_eq("word1_top3", out_data[OUT_BITS-1 -: 3], 0);
        s0 = n_strobe;
        repeat (3 * WIDTH) @(posedge clk);
        #1;
        check_eq("stall_no_strobe", n_strobe - s0, 0);
        check_eq("stall_x_hold", x_out, m_x);
        x0 = n_xfer;
        out_ready = 1'b1;
        k = 0;
        while (n_xfer < x0 + 2 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_eq("stall_two_xfers", n_xfer - x0, 2);
        wait_strobes(1);
        stop_run();

        // Stop while stalled drops the pending word; the loaded one still drains.
        out_ready = 1'b0;
        offer_seed(16'd884, e0);
        wait_strobes(2 * OUT_BITS);
        repeat (2) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check_eq("stall_stop_idle", seed_ready, 1);
        void'(m_words.pop_back());
        s0 = n_strobe;
        repeat (2 * WIDTH) @(posedge clk);
        #1;
        check_eq("idle_no_strobe", n_strobe - s0, 0);
        check_eq("stall_stop_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("drain1_valid", out_valid, 0);
        check_eq("drain1_queue", m_words.size(), 0);

        // Reset in the middle of a squaring.
        offer_seed(16'd200, e0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_words.delete();
        m_x = 0;
        m_part = 0;
        m_cnt = 0;
        check_eq("midrst_x_out", x_out, 0);
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_ready", seed_ready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        offer_seed(16'd200, e0);
        wait_strobes(1);
        check_eq("midrst_x200", last_strobe_x, 40000);
        stop_run();

        // Randomized seeds and consumer back-pressure.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: rs = '0;
                    1: rs = WIDTH'(1);
                    default: rs = WIDTH'($urandom_range(MOD, (1 << WIDTH) - 1));
                endcase
                offer_bad(rs);
            end else begin
                rs = WIDTH'($urandom_range(2, MOD - 1));
                offer_seed(rs, e0);
                ncyc = $urandom_range(100, 500);
                repeat (ncyc) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                stop_run();
            end
        end

        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("final_valid", out_valid, 0);
        check_eq("final_queue", m_words.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
